// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encoding, default latencies,
// FSM state encoding and the arithmetic result bundle.
package mdu_ctrl_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    typedef struct packed {
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
    } arith_t;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // mult/multu/div/divu occupy the unit; mthi/mtlo do not
    function automatic logic is_long_op(input logic [2:0] op);
        return op <= OP_DIVU;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product, quotient and remainder for the MDU.
// Signed divide truncates toward zero; remainder follows dividend.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output arith_t      res
);

    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] dv;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        sgn   = is_signed_op(op);
        ea    = sgn ? {{32{rs[31]}}, rs} : {32'b0, rs};
        eb    = sgn ? {{32{rt[31]}}, rt} : {32'b0, rt};
        neg_a = sgn & rs[31];
        neg_b = sgn & rt[31];
        ma    = neg_a ? (32'd0 - rs) : rs;
        mb    = neg_b ? (32'd0 - rt) : rt;
        // Divisor forced to 1 on zero so the result is defined; it is discarded
        dv    = (rt == 32'd0) ? 32'd1 : mb;
        uq    = ma / dv;
        ur    = ma % dv;

        res.dz   = (rt == 32'd0);
        res.prod = ea * eb;
        res.quo  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        res.rem  = neg_a ? (32'd0 - ur) : ur;
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: multi-cycle FSM, busy counter, pending result
// register and architectural HI/LO.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        pend_q;
    logic               dz_q;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    arith_t             ar;

    mdu_arith u_arith (
        .op  (op),
        .rs  (rs),
        .rt  (rt),
        .res (ar)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                pend_q  <= ar.prod;
                                dz_q    <= 1'b0;
                                cnt_q   <= CNT_W'(MUL_CYCLES);
                                state_q <= ST_MUL;
                                busy_q  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_q  <= {ar.rem, ar.quo};
                                dz_q    <= ar.dz;
                                cnt_q   <= CNT_W'(DIV_CYCLES);
                                state_q <= ST_DIV;
                                busy_q  <= 1'b1;
                            end
                            OP_MTHI: hi_q <= rs;
                            OP_MTLO: lo_q <= rs;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        // Divide by zero keeps the previous HI/LO
                        if (!dz_q) begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Busy is masked under reset: it clears on the reset edge anyway
    assign md_stall = md_use
                    & ((busy_q & ~reset) | (start & is_long_op(op)));

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, random ops
// against an arithmetic reference model, and corner sequences.
module tb_mdu_ctrl;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tv[13];

    mdu_ctrl #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .md_use   (md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [2:0] o);
        if (o <= 3'd1) return MULN;
        if (o <= 3'd3) return DIVN;
        return 0;
    endfunction

    // Architectural effect of one completed op, in plain arithmetic
    function automatic void model(input logic [2:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] h,
                                  inout logic [31:0] l);
        longint p;
        int q;
        int r;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                h = p[63:32];
                l = p[31:0];
            end
            3'd1: begin
                p = longint'(a) * longint'(b);
                h = p[63:32];
                l = p[31:0];
            end
            3'd2: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        l = 32'h8000_0000;
                        h = 32'h0;
                    end else begin
                        q = $signed(a) / $signed(b);
                        r = $signed(a) % $signed(b);
                        l = q;
                        h = r;
                    end
                end
            end
            3'd3: begin
                if (b != 0) begin
                    l = a / b;
                    h = a % b;
                end
            end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endfunction

    // Called at a falling edge with the DUT idle
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic mu,
                          input int ecyc, input logic [31:0] eh,
                          input logic [31:0] el, input string tag);
        int n;
        start  = 1'b1;
        op     = o;
        rs     = a;
        rt     = b;
        md_use = mu;
        #1;
        chk({tag, "_stall_start"}, md_stall, mu & (o <= 3'd3));
        @(negedge clk);
        start = 1'b0;
        rs    = $urandom;
        rt    = $urandom;
        n     = 0;
        while (busy === 1'b1 && n < 200) begin
            md_use = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "_stall_busy"}, md_stall, md_use);
            @(negedge clk);
            n++;
        end
        md_use = 1'b0;
        chk({tag, "_cycles"}, n, ecyc);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        checks   = 0;
        failures = 0;

        tv[0]  = '{3'd4, 32'h11,        32'h0,        32'h11,        32'h0,         0};
        tv[1]  = '{3'd5, 32'h22,        32'h0,        32'h11,        32'h22,        0};
        tv[2]  = '{3'd3, 32'h5,         32'h0,        32'h11,        32'h22,        DIVN};
        tv[3]  = '{3'd0, 32'hFFFFFFFE,  32'h3,        32'hFFFFFFFF,  32'hFFFFFFFA,  MULN};
        tv[4]  = '{3'd2, 32'hFFFFFFF9,  32'h2,        32'hFFFFFFFF,  32'hFFFFFFFD,  DIVN};
        tv[5]  = '{3'd2, 32'h80000000,  32'hFFFFFFFF, 32'h0,         32'h80000000,  DIVN};
        tv[6]  = '{3'd1, 32'hFFFFFFFF,  32'h2,        32'h1,         32'hFFFFFFFE,  MULN};
        tv[7]  = '{3'd3, 32'd100,       32'd7,        32'h2,         32'hE,         DIVN};
        tv[8]  = '{3'd2, 32'd7,         32'hFFFFFFFE, 32'h1,         32'hFFFFFFFD,  DIVN};
        tv[9]  = '{3'd6, 32'h1234,      32'h5,        32'h1,         32'hFFFFFFFD,  0};
        tv[10] = '{3'd2, 32'h0,         32'h0,        32'h1,         32'hFFFFFFFD,  DIVN};
        tv[11] = '{3'd0, 32'h80000000,  32'h80000000, 32'h40000000,  32'h0,         MULN};
        tv[12] = '{3'd7, 32'hDEAD,      32'hBEEF,     32'h40000000,  32'h0,         0};

        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        rs     = '0;
        rt     = '0;
        md_use = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        md_use = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_stall", md_stall, 1'b0);
        md_use = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(tv[i].op, tv[i].rs, tv[i].rt, 1'($urandom_range(0, 1)),
                   tv[i].cyc, tv[i].hi, tv[i].lo, $sformatf("vec%0d", i));
        end
        hi_m = tv[12].hi;
        lo_m = tv[12].lo;

        for (int i = 0; i < 50; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            model(ro, ra, rb, hi_m, lo_m);
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), exp_cycles(ro),
                   hi_m, lo_m, $sformatf("rnd%0d", i));
        end

        // mtlo issued mid-multiply must stall and be dropped
        model(3'd0, 32'hFFFFFFFE, 32'h3, hi_m, lo_m);
        start  = 1'b1;
        op     = 3'd0;
        rs     = 32'hFFFFFFFE;
        rt     = 32'h3;
        md_use = 1'b1;
        #1;
        chk("coll_stall0", md_stall, 1'b1);
        @(negedge clk);
        for (int c = 1; c <= MULN; c++) begin
            start = (c == 2);
            op    = 3'd5;
            rs    = 32'hDEAD_0000;
            #1;
            chk($sformatf("coll_busy_c%0d", c), busy, 1'b1);
            chk($sformatf("coll_stall_c%0d", c), md_stall, 1'b1);
            @(negedge clk);
        end
        start = 1'b0;
        #1;
        chk("coll_busy_end", busy, 1'b0);
        chk("coll_stall_end", md_stall, 1'b0);
        chk("coll_hi", hi, hi_m);
        chk("coll_lo", lo, lo_m);
        md_use = 1'b0;
        @(negedge clk);

        // Reset in cycle 3 of a multu, with a competing start
        start = 1'b1;
        op    = 3'd1;
        rs    = 32'hFFFFFFFF;
        rt    = 32'h2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_busy_c3", busy, 1'b1);
        reset  = 1'b1;
        md_use = 1'b1;
        start  = 1'b0;
        #1;
        chk("abort_stall_nostart", md_stall, 1'b0);
        start = 1'b1;
        op    = 3'd0;
        #1;
        chk("abort_stall_start", md_stall, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_stall", md_stall, 1'b0);
        md_use = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("abort_late_c%0d", c), {busy, hi, lo}, 65'h0);
        end
        hi_m = 32'h0;
        lo_m = 32'h0;

        // mtlo alone never stalls
        start  = 1'b1;
        op     = 3'd5;
        rs     = 32'hABCD;
        md_use = 1'b1;
        #1;
        chk("mtlo_stall", md_stall, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("mtlo_lo", lo, 32'hABCD);
        chk("mtlo_hi", hi, 32'h0);
        chk("mtlo_busy", busy, 1'b0);
        chk("mtlo_stall_after", md_stall, 1'b0);
        md_use = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, meaning busy cycles for a multiply.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for a divide.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage instruction is mult/multu/div/divu/mthi/mtlo.
REQ-006 SHALL have port op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
REQ-007 SHALL have port rs  input  32  E-stage forwarded rs operand.
REQ-008 SHALL have port rt  input  32  E-stage forwarded rt operand.
REQ-009 SHALL have port md_use  input  1  D-stage instruction is any MDU instruction, including mfhi/mflo.
REQ-010 SHALL have port busy  output  1  MDU operation in progress.
REQ-011 SHALL have port md_stall  output  1  stall request to hazard unit.
REQ-012 SHALL have port hi  output  32  architectural HI.
REQ-013 SHALL have port lo  output  32  architectural LO.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV.
REQ-015 In IDLE, start with op 0/1 SHALL latch the 64-bit product into a pending register, load the counter with MUL_CYCLES, and enter MUL.
REQ-016 In IDLE, start with op 2/3 SHALL latch the quotient into pending-lo and the remainder into pending-hi, load the counter with DIV_CYCLES, and enter DIV.
REQ-017 Operands SHALL be sampled only in the start cycle; later changes on rs/rt SHALL have no effect.
REQ-018 mult/div SHALL treat operands as two's complement; multu/divu SHALL treat them as unsigned.
REQ-019 Signed divide SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-020 Divide by zero SHALL still run DIV_CYCLES and SHALL leave hi/lo unchanged at completion.
REQ-021 Signed 0x80000000 / -1 SHALL give lo=0x80000000 and hi=0.
REQ-022 The counter SHALL decrement once per cycle in MUL/DIV.
REQ-023 On the cycle the counter reaches 1, the pending result SHALL commit to hi/lo and the state SHALL return to IDLE.
REQ-024 Consequence of REQ-022/023: busy SHALL be high for exactly N cycles after the start edge.
REQ-025 hi/lo SHALL show the new values on the first cycle busy is low.
REQ-026 In IDLE, start with op 4 SHALL write rs to hi on the next edge, with no busy.
REQ-027 In IDLE, start with op 5 SHALL write rs to lo on the next edge, with no busy.
REQ-028 start while busy=1 SHALL be ignored: no state, counter or hi/lo change.
REQ-029 start with op 6/7 SHALL be ignored.
REQ-030 busy SHALL equal (state != IDLE), registered.
REQ-031 md_stall SHALL equal md_use & (busy | (start & op<=3)), combinational.
REQ-032 md_stall SHALL NOT be asserted by mthi/mtlo alone.
REQ-033 hi/lo SHALL hold their value except at a commit (REQ-023) or an mthi/mtlo write (REQ-026/027).

Reset
REQ-034 When reset is high at a clock edge, the next state SHALL be: state IDLE, counter 0, pending 0, hi 0, lo 0, busy 0.
REQ-035 Reset during MUL/DIV SHALL abort the operation without committing its result.
REQ-036 Reset SHALL take precedence over start in the same cycle.
REQ-037 With reset high, md_stall SHALL be md_use & start & op<=3, and stalls SHALL clear on the next edge.

Structure
REQ-038 A shared package SHALL hold the op encoding constants, the MUL_CYCLES/DIV_CYCLES defaults and the state encoding.
REQ-039 Combinational product/quotient/remainder logic SHALL be placed in one sub-module, mdu_arith.
REQ-040 mdu_ctrl SHALL own the FSM, the counter, the pending register and hi/lo.

Verification
REQ-041 Multiply test: start op0, rs=0xFFFFFFFE, rt=3. Required: busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-042 Divide test: start op2, rs=-7, rt=2. Required: busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-043 Unsigned divide-by-zero test: preload via mthi 0x11, mtlo 0x22, then divu rt=0. Required: busy high 10 cycles, hi=0x11, lo=0x22.
REQ-044 Busy-collision test: start a mult; on cycle 2, assert start op5 with md_use=1. Required: md_stall high through cycle 5, the mtlo is ignored, and lo = the product.
REQ-045 Reset-abort test: start op1 with 0xFFFFFFFF x 2; assert reset on cycle 3. Required: busy=0, hi=lo=0 after the reset edge, and no later commit.
REQ-046 mtlo/md_stall test: in IDLE, start op5 with rs=0xABCD and md_use=1. Required: md_stall=0, lo=0xABCD next cycle, busy stays 0.
